// File: rtl/vga_sync_generator_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vga_sync_generator_pkg
// Brief  : Shared timing constants and stage-0 bundle type for the VGA
//          640x480@60 Hz sync generator.
// Rev    : 1.0  initial release
// ============================================================================
package vga_sync_generator_pkg;

  // Visible frame geometry used by the image generator side.
  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;

  // Default 640x480@60 timing (pixel clocks / lines).
  localparam int DEF_H_ACTIVE = FRAME_WIDTH;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = FRAME_HEIGHT;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Counter and coordinate width; every total must stay below 2**CNT_W.
  localparam int CNT_W = 12;

  // Everything computed from the counters in the first pipeline stage.
  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             active;
    logic             frame_tick;
    logic             hs;   // sync asserted (polarity applied later)
    logic             vs;
  } stage0_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_generator_sync_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vga_sync_generator_sync_counter
// Brief  : Modulo-N up counter with enable and combinational wrap flag.
// Rev    : 1.0  initial release
// ============================================================================
module vga_sync_generator_sync_counter #(
  parameter int N = 800,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Wrap is flagged on the enabled cycle that returns the count to zero.
  assign wrap = en && (count == LAST);

  // Count 0..N-1 while enabled, restarting from zero after the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vga_sync_generator
// Brief  : VGA timing generator. Stage 0 turns the counters into pixel
//          coordinates and raw sync flags; stage 1 registers the image
//          generator's color together with the syncs so the pins stay aligned.
// Rev    : 1.0  initial release
// ============================================================================
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             CLOCK_25,
  input  logic             reset_n,
  input  logic [2:0]       color,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             frame_tick,
  output logic             VGA_R,
  output logic             VGA_G,
  output logic             VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             unused_v_wrap;  // frame end is derived from v_cnt instead
  stage0_t          s0_d;
  stage0_t          s0_q;
  logic [2:0]       rgb_q;
  logic             hs_q;
  logic             vs_q;

  vga_sync_generator_sync_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk   (CLOCK_25),
    .rst_n (reset_n),
    .en    (1'b1),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_sync_generator_sync_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk   (CLOCK_25),
    .rst_n (reset_n),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (unused_v_wrap)
  );

  // Decode the current counter position into 1-based coordinates and flags.
  always_comb begin
    s0_d            = '0;
    s0_d.active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    if (s0_d.active) begin
      s0_d.x = h_cnt + 1'b1;
      s0_d.y = v_cnt + 1'b1;
    end
    s0_d.frame_tick = (h_cnt == '0) && (v_cnt == V_ACT);
    s0_d.hs         = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    s0_d.vs         = (v_cnt >= VS_START) && (v_cnt <= VS_END);
  end

  // Stage 0: coordinates presented to the image generator.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      s0_q <= '0;
    end else begin
      s0_q <= s0_d;
    end
  end

  // Stage 1: pin registers; color is blanked and syncs get their polarity.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= 3'b000;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      rgb_q <= s0_q.active ? color : 3'b000;
      hs_q  <= s0_q.hs ? SYNC_POL : ~SYNC_POL;
      vs_q  <= s0_q.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign x                     = s0_q.x;
  assign y                     = s0_q.y;
  assign active                = s0_q.active;
  assign frame_tick            = s0_q.frame_tick;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HS                = hs_q;
  assign VGA_VS                = vs_q;

endmodule
`default_nettype wire
